pc_next_unit: RTL
=================

Name: pc_next_unit

Overview:
Registered program-counter unit for the single-issue CPU. It replaces the two-input next-PC select with a parametrised priority selector over sequential, branch, jump, jump-register and exception sources. It holds the PC register, supports pipeline stall, and buffers a redirect that arrives while stalled so it is not lost. It also detects misaligned targets. It sits between the control unit/branch comparator and the instruction-memory address port.

Parameters:
WIDTH, 32, PC and target width in bits
RESET_VEC, 32'h0000_0000, PC value loaded on reset
EXC_VEC, 32'h8000_0180, PC loaded on exception or misaligned target
INC, 4, sequential increment

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold PC this cycle
branch_taken  in  1  conditional branch resolved taken
branch_target  in  WIDTH  branch destination
jump  in  1  direct jump (J/JAL)
jump_target  in  WIDTH  jump destination
jr  in  1  register jump (JR/JALR)
jr_target  in  WIDTH  register value
exception  in  1  trap request
pc  out  WIDTH  current PC (registered)
pc_plus_inc  out  WIDTH  pc + INC, combinational
redirect  out  1  registered; high the cycle after pc loaded with a non-sequential value
pending  out  1  registered; a buffered redirect is waiting
misalign_err  out  1  registered; one-cycle pulse when a misaligned target was trapped

Behaviour:
- Reset (rst=1 at clk edge): pc=RESET_VEC, redirect=0, pending=0, misalign_err=0, pending target register cleared. Reset overrides stall and all requests, including a buffered redirect.
- Request priority: exception > jr > jump > branch_taken > sequential.
- Misaligned: the selected jr/jump/branch target has bits[1:0] != 0. It is treated as an exception: the target becomes EXC_VEC and misalign_err pulses on the cycle pc takes EXC_VEC.
- pc_plus_inc = pc + INC, truncated to WIDTH bits, so it wraps modulo 2^WIDTH (e.g. FFFF_FFFC -> 0000_0000).
- States: RUN (pending=0), HELD (pending=1).
- RUN, stall=0:
  - pc <= highest-priority target.
  - redirect <= 1 if a non-sequential target was selected, else 0.
- RUN, stall=1:
  - pc holds and redirect <= 0.
  - If any request is present, capture the resolved target (after the misalign check) and go to HELD.
  - A captured misalign also records the error flag.
- HELD, stall=1:
  - pc holds.
  - A new exception (or misalign) overwrites the buffer. Other new requests are ignored; the first captured redirect wins.
- HELD, stall=0:
  - If exception=1 in this cycle, pc <= EXC_VEC. Otherwise pc <= buffered target and new jr/jump/branch inputs are discarded.
  - redirect <= 1, pending <= 0, return to RUN.
  - misalign_err pulses now if it was recorded.
- Latency: a request sampled at edge N appears on pc after edge N when unstalled. When buffered, it appears after the first unstalled edge.
- A request asserted together with stall is never dropped.
- Requests are not latched when stall=0 and rst=1.

Test Plan:
- Reset: rst=1 for 2 cycles -> pc=0000_0000, redirect=0, pending=0. Release, 3 idle cycles -> pc 0,4,8,C, redirect=0.
- Priority: pc=0000_0010; jump=1 (0000_0400), branch_taken=1 (0000_0200), jr=1 (0000_0800) in one cycle -> pc=0000_0800, redirect=1 next cycle. Add exception=1 -> pc=8000_0180.
- Stalled redirect: stall=1 three cycles; branch_taken=1, target 0000_0100 in the first stall cycle only -> pc holds, pending=1. A later jump (0000_0300) in the 2nd stall cycle is ignored. On unstall -> pc=0000_0100, redirect=1, pending=0.
- Exception during HELD: buffered branch 0000_0100; exception=1 while stalled -> on unstall pc=8000_0180, pending clears.
- Misalign: jump_target=0000_0402 unstalled -> pc=8000_0180, misalign_err=1 for exactly one cycle, redirect=1.
- Wrap and reset mid-hold: pc=FFFF_FFFC -> pc_plus_inc=0000_0000, next pc=0. With pending=1, rst=1 -> pc=RESET_VEC, pending=0; the buffered target is never applied.

Source files
------------

// File: rtl/pc_next_unit_if.sv
// ---------------------------------------------------------------------------
// pc_next_unit_if
//   Bundles the next-PC request/response signals between the control path
//   (branch comparator, control unit, trap logic) and the PC unit.
//
//   master : control side. It drives stall and the redirect requests, and it
//            observes the PC and the status flags.
//   slave  : PC unit side.
//
//   Signals
//     stall          hold PC this cycle
//     branch_taken   conditional branch resolved taken, to branch_target
//     jump           direct jump (J/JAL), to jump_target
//     jr             register jump (JR/JALR), to jr_target
//     exception      trap request
//     pc             current PC (registered)
//     pc_plus_inc    pc + INC (combinational, wraps)
//     redirect       PC was loaded with a non-sequential value last edge
//     pending        a redirect captured under stall is waiting
//     misalign_err   one-cycle pulse when a misaligned target was trapped
// ---------------------------------------------------------------------------
interface pc_next_unit_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             jr;
  logic [WIDTH-1:0] jr_target;
  logic             exception;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_inc;
  logic             redirect;
  logic             pending;
  logic             misalign_err;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, exception,
    input  pc, pc_plus_inc, redirect, pending, misalign_err
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, exception,
    output pc, pc_plus_inc, redirect, pending, misalign_err
  );
endinterface

// File: rtl/pc_next_unit.sv
// ---------------------------------------------------------------------------
// pc_next_unit
//   This is the registered program counter for the single-issue CPU. Each
//   cycle it picks the next PC by fixed priority:
//     exception > jr > jump > branch_taken > sequential (pc + INC)
//   A jr/jump/branch target with a nonzero bits[1:0] field is trapped. The PC
//   goes to EXC_VEC and misalign_err pulses.
//   When stall is high, the PC holds. A redirect that arrives while stalled is
//   kept in a one-entry buffer. The unit then sits in HELD until the first
//   unstalled edge applies it. While HELD, only an exception or a misalign
//   trap can replace the buffered target.
//
//   Ports
//     clk   rising-edge clock
//     rst   synchronous active-high reset; it overrides stall, requests and
//           any buffered redirect
//     bus   pc_next_unit_if.slave (requests in, pc and status flags out)
// ---------------------------------------------------------------------------
module pc_next_unit #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VEC = 32'h0000_0000,
  parameter logic [WIDTH-1:0]   EXC_VEC   = 32'h8000_0180,
  parameter int                 INC       = 4
) (
  input  logic          clk,
  input  logic          rst,
  pc_next_unit_if.slave bus
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  typedef enum logic {
    RUN  = 1'b0,   // no buffered redirect
    HELD = 1'b1    // a redirect captured under stall is waiting
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pc_q;
  logic             redirect_q;
  logic             misalign_q;
  logic [WIDTH-1:0] buf_target_q;
  logic             buf_misalign_q;

  // Request resolution
  logic             nonseq_req;
  logic             any_req;
  logic [WIDTH-1:0] cand_target;
  logic             misalign;
  logic [WIDTH-1:0] resolved_target;
  logic [WIDTH-1:0] pc_plus_inc;

  // NOTE: assign every always_comb output a default value first. If some path
  // leaves an output unassigned, synthesis infers a latch.
  always_comb begin
    cand_target = '0;
    nonseq_req  = bus.jr | bus.jump | bus.branch_taken;
    any_req     = bus.exception | nonseq_req;

    if (bus.jr)                cand_target = bus.jr_target;
    else if (bus.jump)         cand_target = bus.jump_target;
    else if (bus.branch_taken) cand_target = bus.branch_target;

    // An exception outranks every target, so it can never be a misalign.
    misalign = !bus.exception && nonseq_req && (cand_target[1:0] != 2'b00);

    resolved_target = (bus.exception || misalign) ? EXC_VEC : cand_target;
  end

  // This wraps modulo 2^WIDTH by construction.
  assign pc_plus_inc = pc_q + INC_W;

  // NOTE: use non-blocking assignments for all state in always_ff. Then every
  // register samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      pc_q           <= RESET_VEC;
      redirect_q     <= 1'b0;
      misalign_q     <= 1'b0;
      buf_target_q   <= '0;
      buf_misalign_q <= 1'b0;
    end else begin
      // redirect and misalign_err are single-cycle pulses by default.
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;

      case (state_q)
        RUN: begin
          if (!bus.stall) begin
            pc_q       <= any_req ? resolved_target : pc_plus_inc;
            redirect_q <= any_req;
            misalign_q <= misalign;
          end else if (any_req) begin
            buf_target_q   <= resolved_target;
            buf_misalign_q <= misalign;
            state_q        <= HELD;
          end
        end

        HELD: begin
          if (bus.stall) begin
            // The first captured redirect wins unless a trap arrives.
            if (bus.exception || misalign) begin
              buf_target_q   <= EXC_VEC;
              buf_misalign_q <= misalign;
            end
          end else begin
            // A live exception beats the buffer. New jr/jump/branch inputs
            // in this cycle are dropped.
            pc_q       <= bus.exception ? EXC_VEC : buf_target_q;
            redirect_q <= 1'b1;
            misalign_q <= buf_misalign_q;
            state_q    <= RUN;
          end
        end

        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus_inc  = pc_plus_inc;
  assign bus.redirect     = redirect_q;
  assign bus.pending      = (state_q == HELD);
  assign bus.misalign_err = misalign_q;

endmodule
